// File: rtl/smaesh_op_scheduler.sv
// Operation scheduler for the masked AES top: serialises reseed, re-key and data
// operations so the PRNG, key holder and AES core never run concurrently.
module smaesh_op_scheduler #(
   parameter int CNT_W         = 16,
   parameter int RESEED_PERIOD = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_seed_valid,
   input  logic             in_key_valid,
   input  logic             in_data_valid,
   input  logic             data_fire,
   input  logic             aes_busy,
   input  logic             ksu_busy,
   input  logic             prng_busy,
   input  logic             prng_out_valid,
   output logic             prng_start_reseed,
   output logic             ksu_start_fetch,
   output logic             data_grant,
   output logic             in_seed_ready,
   output logic             seed_required,
   output logic [CNT_W-1:0] blocks_since_seed,
   output logic [1:0]       sched_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RESEED = 2'd1,
      ST_REKEY  = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [31:0]      PERIOD  = RESEED_PERIOD;

   state_t           state_q, state_d;
   logic             seen_q, seen_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             seed_req_q, seed_req_d;
   logic             prev_prng_busy_q;
   logic             op_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         seen_q           <= 1'b0;
         cnt_q            <= '0;
         seed_req_q       <= 1'b1;
         prev_prng_busy_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         seen_q           <= seen_d;
         cnt_q            <= cnt_d;
         seed_req_q       <= seed_req_d;
         prev_prng_busy_q <= prng_busy;
      end
   end

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   always_comb begin
      state_d           = state_q;
      seen_d            = seen_q;
      cnt_d             = cnt_q;
      seed_req_d        = seed_req_q;
      prng_start_reseed = 1'b0;
      ksu_start_fetch   = 1'b0;
      data_grant        = 1'b0;
      op_busy           = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_seed_valid && !aes_busy && !ksu_busy) begin
               prng_start_reseed = 1'b1;
               state_d           = ST_RESEED;
            end else if (in_key_valid && !seed_req_q && !aes_busy && !prng_busy) begin
               ksu_start_fetch = 1'b1;
               state_d         = ST_REKEY;
            end else begin
               data_grant = in_data_valid && !seed_req_q && prng_out_valid && !ksu_busy;
               // A data_fire without a grant is a protocol error and is dropped.
               if (data_grant && data_fire) begin
                  state_d = ST_RUN;
                  cnt_d   = cnt_inc;
                  if ((PERIOD != 32'd0) && (32'(cnt_inc) == PERIOD))
                     seed_req_d = 1'b1;
               end
            end
         end
         default: begin
            // Each operation ends on the falling edge of its sub-block's busy.
            case (state_q)
               ST_RESEED: op_busy = prng_busy;
               ST_REKEY:  op_busy = ksu_busy;
               default:   op_busy = aes_busy;
            endcase
            if (op_busy) begin
               seen_d = 1'b1;
            end else if (seen_q) begin
               seen_d  = 1'b0;
               state_d = ST_IDLE;
               if (state_q == ST_RESEED) begin
                  cnt_d      = '0;
                  seed_req_d = 1'b0;
               end
            end
         end
      endcase
   end

   assign in_seed_ready     = prng_busy && !prev_prng_busy_q;
   assign seed_required     = seed_req_q;
   assign blocks_since_seed = cnt_q;
   assign sched_state       = state_q;

endmodule
